arith_sequencer: RTL
====================

# arith_sequencer

Upstream feeder for the arithmetic pipeline. It collects a group of top-k gating logits and replays them to the pipeline twice: an exp+sum pass (mode 0), then a normalise pass (mode 1), with a drain gap after each pass. Between groups it forwards expert results from the output collector as GeLU (mode 2) or aggregate (mode 3) operations. All pipeline-side outputs are registered, and the pipeline accepts one operation per cycle without back-pressure.

## Interface
Parameters:
- `K_MAX`, 8, maximum logits per gating group.
- `DRAIN_CYC`, 4, idle cycles inserted after each pass; must be at least the adder latency.
- `CNT_W`, `$clog2(K_MAX+1)`, width of the entry counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `gate_valid`  in  1  logit beat valid (from top-k).
- `gate_ready`  out  1  logit beat accepted.
- `gate_data`  in  16  FP16 logit.
- `gate_last`  in  1  final logit of the group.
- `res_valid`  in  1  expert result valid (from output collector).
- `res_ready`  out  1  expert result accepted.
- `res_data`  in  16  FP16 expert output.
- `res_psum`  in  16  FP16 partial sum, used only when `res_gelu`=0.
- `res_gelu`  in  1  1 selects mode 2, 0 selects mode 3.
- `ap_valid`  out  1  operation valid to the pipeline.
- `ap_data`  out  16  operand.
- `ap_psum`  out  16  partial sum; 0 except in mode 3.
- `ap_mode`  out  2  0 exp+sum, 1 div, 2 GeLU, 3 AGG.
- `busy`  out  1  high in every state except IDLE.
- `norm_done`  out  1  one-cycle pulse when a group finishes.
- `ovf_err`  out  1  sticky: a group exceeded `K_MAX`.

## Operation
- States: IDLE, EXP, DRAIN_E, DIV, DRAIN_D.
- IDLE
  - `gate_ready`=1.
  - On each gate handshake: `buf[cnt]` <= `gate_data` and `cnt`++.
  - Leave for EXP when the accepted beat has `gate_last`=1, or when it brings `cnt` to `K_MAX`.
  - In the `K_MAX` case without `gate_last`, set `ovf_err`. Later beats start a new group.
- Forwarding in IDLE
  - `res_ready` = IDLE && `cnt`==0 && !`gate_valid`, so gate input has priority and a group is never interleaved with results.
  - On a res handshake, the next cycle carries `ap_valid`=1, `ap_mode` = `res_gelu` ? 2 : 3, `ap_data`=`res_data`, and `ap_psum` = `res_psum` (0 in mode 2).
- EXP
  - Issue `buf[0..cnt-1]` with mode 0, one entry per cycle, `ap_psum`=0.
  - Go to DRAIN_E after the last entry.
- DRAIN_E: `ap_valid`=0 for `DRAIN_CYC` cycles, then DIV.
- DIV: issue `buf[0..cnt-1]` with mode 1, then DRAIN_D.
- DRAIN_D
  - `ap_valid`=0 for `DRAIN_CYC` cycles.
  - Then return to IDLE with `cnt`=0 and pulse `norm_done` for exactly one cycle, coinciding with the first IDLE cycle.
- `gate_ready`=0 and `res_ready`=0 in every state except IDLE.
- While `ap_valid`=0, `ap_data`/`ap_psum`/`ap_mode` hold their last issued values.
- `ovf_err` clears only on `rst`.
- Reset, asserted at any time: state IDLE, `cnt`=0, buffer cleared, and every output 0 (`gate_ready` becomes 1 once `rst` deasserts).

## Timing
- Gate handshake at edge t with `gate_last`: state is EXP from t. Mode-0 entries appear on `ap_*` in cycles t+1 … t+cnt.
- Drain gap: cycles t+cnt+1 … t+cnt+`DRAIN_CYC`.
- Mode-1 entries follow immediately for `cnt` cycles, then the second drain gap, then `norm_done`.
- Total group time from the last accept to `norm_done`: 2·cnt + 2·`DRAIN_CYC` + 1 cycles.
- Result forwarding latency is 1 cycle, with a sustained throughput of 1 per cycle.
- A one-entry group (`gate_last` on the first beat) is legal and runs 1 + 4 + 1 + 4 cycles.
- Buffer read index wraps to 0 at each pass start. The buffer is never written outside IDLE.

## Structure
- Shared package `arith_pkg`:
  - mode constants `MODE_EXP`=0, `MODE_DIV`=1, `MODE_GELU`=2, `MODE_AGG`=3;
  - the sequencer state encoding;
  - the FP16 width constant.
- Sub-module `arith_seq_buf`: a `K_MAX`×16 register file with one write port and one read port, synchronous write, combinational read, async-high reset clear.
- FSM, counters and the output register stay in the top.

## Test plan
- K=3 group (0x3C00, 0x4000, 0x4200, last on the third) with `DRAIN_CYC`=4 →
  - mode 0 with those values in cycles 1–3;
  - `ap_valid`=0 in cycles 4–7;
  - mode 1 with the same values in cycles 8–10;
  - `norm_done` in cycle 15.
- `res_valid` held with `res_gelu` alternating 1/0, data 0x1234, psum 0x5678 →
  - back-to-back `ap_mode` 2/3, each 1 cycle later;
  - `ap_psum` 0 for GeLU and 0x5678 for AGG.
- `gate_valid` and `res_valid` both asserted in IDLE → gate accepted, `res_ready`=0 until `norm_done`; then the result is forwarded.
- Nine logits without `gate_last` (`K_MAX`=8) →
  - the group runs with cnt=8 and `ovf_err`=1;
  - the ninth beat is accepted as entry 0 of the next group after `norm_done`.
- `rst` pulsed during DIV → all outputs 0 and `busy`=0 immediately. A new 1-entry group afterwards produces a single mode-0 beat and a single mode-1 beat.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic pipeline feeder: operation modes,
// sequencer state encoding and the operand word layout.
package arith_pkg;

  localparam int FP16_W = 16;

  localparam logic [1:0] MODE_EXP  = 2'd0;
  localparam logic [1:0] MODE_DIV  = 2'd1;
  localparam logic [1:0] MODE_GELU = 2'd2;
  localparam logic [1:0] MODE_AGG  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP,
    S_DRAIN_E,
    S_DIV,
    S_DRAIN_D
  } seq_state_t;

  typedef struct packed {
    logic [1:0]        mode;
    logic [FP16_W-1:0] data;
    logic [FP16_W-1:0] psum;
  } ap_op_t;

endpackage

// File: rtl/arith_seq_buf.sv
// Logit buffer for one gating group: one synchronous write port, one
// combinational read port, cleared on reset.
module arith_seq_buf
  import arith_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [FP16_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [FP16_W-1:0] rdata
);

  logic [DEPTH-1:0][FP16_W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we && waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  // Address is compared rather than used as an index so the counter width
  // need not match log2(DEPTH).
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++)
      if (raddr == AW'(i)) rdata = mem[i];
  end

endmodule

// File: rtl/arith_sequencer.sv
// Collects a gating group and replays it as an exp+sum pass then a normalise
// pass; forwards expert results as GeLU/AGG ops while idle between groups.
module arith_sequencer
  import arith_pkg::*;
#(
  parameter int K_MAX     = 8,
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = $clog2(K_MAX + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gate_valid,
  output logic        gate_ready,
  input  logic [15:0] gate_data,
  input  logic        gate_last,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [15:0] res_data,
  input  logic [15:0] res_psum,
  input  logic        res_gelu,
  output logic        ap_valid,
  output logic [15:0] ap_data,
  output logic [15:0] ap_psum,
  output logic [1:0]  ap_mode,
  output logic        busy,
  output logic        norm_done,
  output logic        ovf_err
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  seq_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, ridx;
  logic [DW-1:0]     dcnt;
  logic              gate_hs, res_hs, cnt_full, last_ent, drain_end;
  logic              issue, done;
  ap_op_t            op, op_q;
  logic [FP16_W-1:0] rd_data;

  assign gate_ready = (state == S_IDLE) && !rst;
  assign res_ready  = (state == S_IDLE) && (cnt == '0) && !gate_valid && !rst;
  assign busy       = (state != S_IDLE);
  assign gate_hs    = gate_valid && gate_ready;
  assign res_hs     = res_valid && res_ready;
  assign cnt_full   = (cnt == CNT_W'(K_MAX - 1));
  assign last_ent   = (ridx == cnt - CNT_W'(1));
  // DRAIN_D holds one extra cycle so norm_done lands right after the last
  // gap cycle, in step with the ap_* register stage.
  assign drain_end  = (state == S_DRAIN_E) ? (dcnt == DW'(DRAIN_CYC - 1))
                                           : (dcnt == DW'(DRAIN_CYC));

  arith_seq_buf #(.DEPTH(K_MAX), .AW(CNT_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (gate_hs),
    .waddr (cnt),
    .wdata (gate_data),
    .raddr (ridx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    op        = '{mode: MODE_EXP, data: rd_data, psum: '0};
    unique case (state)
      S_IDLE: begin
        if (gate_hs && (gate_last || cnt_full)) state_nxt = S_EXP;
        if (res_hs) begin
          issue   = 1'b1;
          op.mode = res_gelu ? MODE_GELU : MODE_AGG;
          op.data = res_data;
          op.psum = res_gelu ? '0 : res_psum;
        end
      end
      S_EXP: begin
        issue = 1'b1;
        if (last_ent) state_nxt = S_DRAIN_E;
      end
      S_DRAIN_E: if (drain_end) state_nxt = S_DIV;
      S_DIV: begin
        issue   = 1'b1;
        op.mode = MODE_DIV;
        if (last_ent) state_nxt = S_DRAIN_D;
      end
      S_DRAIN_D: begin
        if (drain_end) begin
          state_nxt = S_IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      ridx      <= '0;
      dcnt      <= '0;
      ap_valid  <= 1'b0;
      op_q      <= '0;
      norm_done <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      ap_valid  <= issue;
      norm_done <= done;
      if (issue) op_q <= op;
      if (gate_hs) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt_full && !gate_last) ovf_err <= 1'b1;
      end else if (done) begin
        cnt <= '0;
      end
      // Read index and drain counter restart on every state change.
      if (state_nxt != state)                     ridx <= '0;
      else if (state == S_EXP || state == S_DIV)  ridx <= ridx + CNT_W'(1);
      if (state_nxt != state)                          dcnt <= '0;
      else if (state == S_DRAIN_E || state == S_DRAIN_D) dcnt <= dcnt + DW'(1);
    end
  end

  assign ap_mode = op_q.mode;
  assign ap_data = op_q.data;
  assign ap_psum = op_q.psum;

endmodule
